ysyx_22041752_clint_arb: RTL
============================

# ysyx_22041752_clint_arb

Two-port arbiter and transaction sequencer in front of the core-local interruptor (mtime/mtimecmp register port). It shares the single CLINT access port between requester 0 (LSU MMIO path) and requester 1 (debug/DMA path). It grants round-robin, drives the one-cycle CLINT strobe, and waits for the registered read-valid. Every accepted transaction returns exactly one response, with an error flag when a read gets no data.

## Interface
- TIMEOUT, 4: cycles spent in WAIT_RD without `c_rdat_v` before an error response; legal range 2..255.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  request; held with its fields stable until the matching gnt
- m0_wen / m1_wen  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  64  byte address, passed through unchanged
- m0_wdata / m1_wdata  in  64  write data
- m0_gnt / m1_gnt  out  1  request accepted this cycle; combinational
- m0_rsp_v / m1_rsp_v  out  1  one-cycle response pulse; registered
- m0_rdata / m1_rdata  out  64  read data, valid with rsp_v; 0 for writes and errors
- m0_err / m1_err  out  1  error flag, valid with rsp_v
- c_en  out  1  CLINT access strobe
- c_wen  out  1  CLINT write enable
- c_addr  out  64  CLINT address
- c_wdata  out  64  CLINT write data
- c_rdata  in  64  CLINT read data
- c_rdat_v  in  1  CLINT read valid; arrives 1 cycle after c_en on mapped addresses, never on unmapped ones

## Operation
- The FSM has two states, IDLE and WAIT_RD. Reset sets: state IDLE, RR pointer = m0, timeout counter 0, all rsp_v/err 0, all rdata 0.
- **Arbitration (IDLE only)**
  - If only one req is high, that requester wins.
  - If both are high, the requester the RR pointer selects wins. The pointer then moves to the other requester.
  - The pointer updates only on a grant.
- **Grant cycle (IDLE with a winner)**
  - Outputs: winner's gnt = 1, c_en = 1, c_wen = winner's wen, c_addr/c_wdata = winner's fields.
  - Outside a grant cycle: c_en = 0, c_wen = 0, c_addr = 0, c_wdata = 0. c_wen must never be high without c_en, because the CLINT commits writes on wen alone.
  - The owner ID of the granted requester is latched.
- **Write**
  - The state stays IDLE.
  - The owner's rsp_v is registered high for the next cycle with err = 0 and rdata = 0.
  - The CLINT does not acknowledge writes. An unmapped write is silently dropped and still responds with err = 0.
- **Read**
  - Go to WAIT_RD and clear the counter.
  - In WAIT_RD, if c_rdat_v = 1: register c_rdata into the owner's rdata, set rsp_v = 1 and err = 0 for one cycle, and return to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without c_rdat_v: rsp_v = 1, err = 1, rdata = 0, and return to IDLE.
- **Ignored inputs**
  - c_rdat_v in IDLE is ignored.
  - The non-owner's req is never granted while in WAIT_RD.
- The non-owner's rsp_v, err and rdata stay 0 on every cycle.
- **Reset mid-transaction**: the outstanding response is discarded and no rsp_v is issued. A CLINT write already strobed is not rolled back.

## Timing
- The grant is issued in the same cycle the req is sampled in IDLE; zero-cycle arbitration latency.
- Write: gnt at cycle T, rsp_v at T+1. A new grant is possible at T+1, so writes sustain 1 per cycle.
- Mapped read: gnt at T, c_rdat_v at T+1, rsp_v with data at T+2. The next grant is possible at T+2.
- Unmapped read: gnt at T, rsp_v with err = 1 at T+TIMEOUT.
- rsp_v is never high for more than 1 cycle per transaction.
- Exactly one response is issued per grant.
- Counter width is clog2(TIMEOUT+1) and it never wraps.

## Test plan
- Reset, then m0 read of 0x0200_bff8 after 10 cycles of mtime counting: m0_gnt at T, m0_rsp_v at T+2 with rdata equal to mtime as sampled at T, err 0. m1 outputs stay 0.
- Both req high continuously, m0/m1 writing mtimecmp 0x10/0x20 alternately:
  - grants alternate m0, m1, m0, … starting with m0;
  - one rsp_v per grant at grant+1;
  - mtimecmp read back afterwards equals the last value written.
- m1 reads the unmapped address 0x0200_0000 with TIMEOUT=4: m1_rsp_v at T+4, m1_err = 1, m1_rdata = 0. m0_req raised at T+1 is granted no earlier than T+4.
- m0 read in flight (WAIT_RD) while m1_req is high: m1_gnt stays 0 until m0_rsp_v. m1 is then granted in that cycle, because the pointer favours m1.
- reset asserted in the WAIT_RD cycle of an m0 read: no m0_rsp_v is issued, the FSM is back in IDLE, and the next simultaneous request is granted to m0.
- A write cycle drives c_en = 1 and c_wen = 1. In all other cycles c_wen = 0, checked by assertion over a random 1000-cycle mixed read/write run.

Source files
------------

// File: rtl/ysyx_22041752_clint_arb.sv
// ysyx_22041752_clint_arb
// Shares the single CLINT register port between requester 0 (LSU MMIO) and
// requester 1 (debug/DMA). Round-robin grant in IDLE, a one-cycle CLINT
// strobe on the grant cycle, and exactly one registered response per grant.
// Reads that never see c_rdat_v are closed with an error response after
// TIMEOUT cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no read outstanding; arbitrate and strobe the CLINT
// WAIT_RD | read strobed; waiting for c_rdat_v or the timeout
module ysyx_22041752_clint_arb #(
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rsp_v,
  output logic [63:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rsp_v,
  output logic [63:0] m1_rdata,
  output logic        m1_err,

  output logic        c_en,
  output logic        c_wen,
  output logic [63:0] c_addr,
  output logic [63:0] c_wdata,
  input  logic [63:0] c_rdata,
  input  logic        c_rdat_v
);

  // Counter holds 0..TIMEOUT-1 and never wraps.
  localparam int CW = $clog2(TIMEOUT + 1);
  // The error response is registered on the cycle the counter still reads
  // TIMEOUT-2, so it becomes visible together with the counter at TIMEOUT-1,
  // exactly TIMEOUT cycles after the grant.
  localparam logic [CW-1:0] ERR_AT = CW'(TIMEOUT - 2);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  state_t        state;
  logic          ptr;
  logic          owner;
  logic [CW-1:0] cnt;

  logic          win_v;
  logic          win_id;
  logic          sel_wen;
  logic [63:0]   sel_addr;
  logic [63:0]   sel_wdata;

  // Arbitration: only in IDLE, and never while reset is held so that no
  // grant is issued whose response the reset would discard.
  always_comb begin
    win_v  = 1'b0;
    win_id = 1'b0;
    if ((state == IDLE) && !reset) begin
      if (m0_req && m1_req) begin
        win_v  = 1'b1;
        win_id = ptr;
      end else if (m0_req) begin
        win_v  = 1'b1;
        win_id = 1'b0;
      end else if (m1_req) begin
        win_v  = 1'b1;
        win_id = 1'b1;
      end
    end
  end

  // Winner's request fields, muxed onto the CLINT port.
  always_comb begin
    sel_wen   = win_id ? m1_wen   : m0_wen;
    sel_addr  = win_id ? m1_addr  : m0_addr;
    sel_wdata = win_id ? m1_wdata : m0_wdata;
  end

  assign m0_gnt  = win_v & ~win_id;
  assign m1_gnt  = win_v &  win_id;

  // The CLINT commits writes on wen alone, so wen is qualified by the strobe
  // and all fields are zeroed outside the grant cycle.
  assign c_en    = win_v;
  assign c_wen   = win_v & sel_wen;
  assign c_addr  = win_v ? sel_addr  : 64'd0;
  assign c_wdata = win_v ? sel_wdata : 64'd0;

  // Transaction sequencer with registered per-requester responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      cnt      <= '0;
      m0_rsp_v <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 64'd0;
      m1_rsp_v <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 64'd0;
    end else begin
      m0_rsp_v <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 64'd0;
      m1_rsp_v <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 64'd0;
      case (state)
        IDLE: begin
          if (win_v) begin
            owner <= win_id;
            ptr   <= ~win_id;
            if (sel_wen) begin
              // Writes are unacknowledged by the CLINT; respond right away.
              if (win_id) m1_rsp_v <= 1'b1;
              else        m0_rsp_v <= 1'b1;
            end else begin
              state <= WAIT_RD;
              cnt   <= '0;
            end
          end
        end
        WAIT_RD: begin
          if (c_rdat_v) begin
            state <= IDLE;
            if (owner) begin
              m1_rsp_v <= 1'b1;
              m1_rdata <= c_rdata;
            end else begin
              m0_rsp_v <= 1'b1;
              m0_rdata <= c_rdata;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == ERR_AT) begin
              state <= IDLE;
              if (owner) begin
                m1_rsp_v <= 1'b1;
                m1_err   <= 1'b1;
              end else begin
                m0_rsp_v <= 1'b1;
                m0_err   <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
